// File: rtl/squash_front_end.sv
// Feeder for the worm_squasher: arbitrates two CPU clients and packs one header plus
// up to 70 payload bytes into ten 56-bit windows. Runs one scan per packet and returns
// the verdict to the client that asked for it.
module squash_front_end #(
  parameter int MAX_BYTES      = 70,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpureq0_i,
  input  logic        cpureq1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  input  logic        hdr_vld_i,
  input  logic [31:0] in_ip_i,
  input  logic [31:0] out_ip_i,
  input  logic [7:0]  proto_i,
  input  logic [15:0] in_port_i,
  input  logic [15:0] out_port_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_last_i,
  output logic        ws_req0_o,
  output logic        ws_req1_o,
  output logic [55:0] ws_payload0_o,
  output logic [55:0] ws_payload1_o,
  output logic [55:0] ws_payload2_o,
  output logic [55:0] ws_payload3_o,
  output logic [55:0] ws_payload4_o,
  output logic [55:0] ws_payload5_o,
  output logic [55:0] ws_payload6_o,
  output logic [55:0] ws_payload7_o,
  output logic [55:0] ws_payload8_o,
  output logic [55:0] ws_payload9_o,
  output logic [31:0] ws_in_ip_o,
  output logic [31:0] ws_out_ip_o,
  output logic [7:0]  ws_proto_o,
  output logic [15:0] ws_in_port_o,
  output logic [15:0] ws_out_port_o,
  input  logic        ws_busy_i,
  input  logic        ws_valid_i,
  input  logic        ws_match_i,
  input  logic [1:0]  ws_clientid_i,
  output logic        resp_vld_o,
  output logic        resp_client_o,
  output logic        resp_match_o,
  output logic        resp_trunc_o,
  output logic        resp_timeout_o
);

  localparam int NUM_WIN   = 10;
  localparam int WIN_BYTES = 7;
  localparam int WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0]        BYTE_CAP  = 7'(MAX_BYTES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  state_e state_r, state_s;

  logic        rr_ptr_r;
  logic        client_r;
  logic        gnt0_r, gnt1_r;
  logic        ws_req0_r, ws_req1_r;
  logic [31:0] in_ip_r, out_ip_r;
  logic [7:0]  proto_r;
  logic [15:0] in_port_r, out_port_r;
  logic [55:0] payload_r [NUM_WIN];
  logic [6:0]  byte_cnt_r;
  logic [3:0]  win_r;
  logic [2:0]  pos_r;
  logic        trunc_r;
  logic        match_acc_r;
  logic        valid_d_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic        resp_vld_r, resp_client_r, resp_match_r, resp_trunc_r, resp_timeout_r;

  logic        grant_s, grant_client_s, flip_ptr_s;
  logic        hdr_take_s, byte_take_s, load_end_s;
  logic        issue_s, done_s, timeout_s, match_hit_s, match_now_s;
  logic [1:0]  client_id_s;

  assign client_id_s = client_r ? 2'b10 : 2'b01;
  assign match_now_s = match_acc_r | (match_hit_s & ws_match_i);

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_s        = state_r;
    grant_s        = 1'b0;
    grant_client_s = 1'b0;
    flip_ptr_s     = 1'b0;
    hdr_take_s     = 1'b0;
    byte_take_s    = 1'b0;
    load_end_s     = 1'b0;
    issue_s        = 1'b0;
    done_s         = 1'b0;
    timeout_s      = 1'b0;
    match_hit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpureq0_i && cpureq1_i) begin
          grant_s        = 1'b1;
          grant_client_s = rr_ptr_r;
          flip_ptr_s     = 1'b1;
          state_s        = ST_HDR;
        end else if (cpureq0_i) begin
          grant_s        = 1'b1;
          grant_client_s = 1'b0;
          state_s        = ST_HDR;
        end else if (cpureq1_i) begin
          grant_s        = 1'b1;
          grant_client_s = 1'b1;
          state_s        = ST_HDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (hdr_vld_i) begin
          hdr_take_s = 1'b1;
          state_s    = ST_LOAD;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        byte_take_s = byte_vld_i;
        if (byte_vld_i && byte_last_i) begin
          load_end_s = 1'b1;
          state_s    = ST_ISSUE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_ISSUE: begin
        if (!ws_busy_i) begin
          issue_s = 1'b1;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // the squasher reports match one cycle after valid, so the delayed valid also qualifies
        match_hit_s = (ws_valid_i && (ws_clientid_i == client_id_s)) || valid_d_r;
        if (valid_d_r && !ws_valid_i) begin
          done_s  = 1'b1;
          state_s = ST_RESP;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_s = 1'b1;
          state_s   = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, round-robin pointer and registered grants
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= 1'b0;
      client_r <= 1'b0;
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (flip_ptr_s) begin
        rr_ptr_r <= ~rr_ptr_r;
      end
      if (grant_s) begin
        client_r <= grant_client_s;
        gnt0_r   <= ~grant_client_s;
        gnt1_r   <= grant_client_s;
      end else if (load_end_s) begin
        gnt0_r <= 1'b0;
        gnt1_r <= 1'b0;
      end
    end
  end

  // Header capture; held through the scan
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      in_ip_r    <= 32'd0;
      out_ip_r   <= 32'd0;
      proto_r    <= 8'd0;
      in_port_r  <= 16'd0;
      out_port_r <= 16'd0;
    end else if (hdr_take_s) begin
      in_ip_r    <= in_ip_i;
      out_ip_r   <= out_ip_i;
      proto_r    <= proto_i;
      in_port_r  <= in_port_i;
      out_port_r <= out_port_i;
    end
  end

  // Payload packing: byte k lands in window k/7, MSB-first within the window
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        payload_r[w] <= 56'd0;
      end
      byte_cnt_r <= 7'd0;
      win_r      <= 4'd0;
      pos_r      <= 3'd0;
      trunc_r    <= 1'b0;
    end else if (grant_s) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        payload_r[w] <= 56'd0;
      end
      byte_cnt_r <= 7'd0;
      win_r      <= 4'd0;
      pos_r      <= 3'd0;
      trunc_r    <= 1'b0;
    end else if (byte_take_s) begin
      if (byte_cnt_r < BYTE_CAP) begin
        for (int b = 0; b < WIN_BYTES; b++) begin
          if (pos_r == 3'(b)) begin
            payload_r[win_r][55-8*b -: 8] <= byte_i;
          end
        end
        byte_cnt_r <= byte_cnt_r + 7'd1;
        if (pos_r == 3'd6) begin
          pos_r <= 3'd0;
          win_r <= win_r + 4'd1;
        end else begin
          pos_r <= pos_r + 3'd1;
        end
      end else begin
        trunc_r <= 1'b1;
      end
    end
  end

  // Squasher handshake, verdict accumulation, timeout and response pulse
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_d_r      <= 1'b0;
      ws_req0_r      <= 1'b0;
      ws_req1_r      <= 1'b0;
      match_acc_r    <= 1'b0;
      wait_cnt_r     <= '0;
      resp_vld_r     <= 1'b0;
      resp_client_r  <= 1'b0;
      resp_match_r   <= 1'b0;
      resp_trunc_r   <= 1'b0;
      resp_timeout_r <= 1'b0;
    end else begin
      valid_d_r <= ws_valid_i;
      ws_req0_r <= issue_s & ~client_r;
      ws_req1_r <= issue_s & client_r;
      if (grant_s) begin
        match_acc_r <= 1'b0;
      end else if (match_hit_s && ws_match_i) begin
        match_acc_r <= 1'b1;
      end
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      if (done_s || timeout_s) begin
        resp_vld_r     <= 1'b1;
        resp_client_r  <= client_r;
        resp_match_r   <= done_s & match_now_s;
        resp_trunc_r   <= trunc_r;
        resp_timeout_r <= timeout_s;
      end else begin
        resp_vld_r     <= 1'b0;
        resp_client_r  <= 1'b0;
        resp_match_r   <= 1'b0;
        resp_trunc_r   <= 1'b0;
        resp_timeout_r <= 1'b0;
      end
    end
  end

  assign gnt0_o         = gnt0_r;
  assign gnt1_o         = gnt1_r;
  assign ws_req0_o      = ws_req0_r;
  assign ws_req1_o      = ws_req1_r;
  assign ws_payload0_o  = payload_r[0];
  assign ws_payload1_o  = payload_r[1];
  assign ws_payload2_o  = payload_r[2];
  assign ws_payload3_o  = payload_r[3];
  assign ws_payload4_o  = payload_r[4];
  assign ws_payload5_o  = payload_r[5];
  assign ws_payload6_o  = payload_r[6];
  assign ws_payload7_o  = payload_r[7];
  assign ws_payload8_o  = payload_r[8];
  assign ws_payload9_o  = payload_r[9];
  assign ws_in_ip_o     = in_ip_r;
  assign ws_out_ip_o    = out_ip_r;
  assign ws_proto_o     = proto_r;
  assign ws_in_port_o   = in_port_r;
  assign ws_out_port_o  = out_port_r;
  assign resp_vld_o     = resp_vld_r;
  assign resp_client_o  = resp_client_r;
  assign resp_match_o   = resp_match_r;
  assign resp_trunc_o   = resp_trunc_r;
  assign resp_timeout_o = resp_timeout_r;

endmodule
